flex_counter_ud: RTL and testbench

Parametrised up/down successor to the team's basic rollover counter, used for timers, bit counters and packet-length tracking in the datapath controllers.

---
 rtl/flex_counter_ud.sv | 92 +++++++++
 tb/tb_flex_counter_ud.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter with parallel load, wrap/saturate modes,
// a registered rollover flag and pulse, and a saturating count of wraps.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     count_enable,
    input  logic                     up_dn,
    input  logic                     sat_mode,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic [NUM_WRAP_BITS-1:0] wrap_count
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] step_count;
    logic                    step_wrap;
    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    next_wrap;
    logic [NUM_CNT_BITS-1:0] terminal;

    // Successor of the current count for one enabled edge; R=0 pins the count at 0.
    always_comb begin
        step_count = count_out;
        step_wrap  = 1'b0;
        if (rollover_val == '0) begin
            step_count = '0;
        end else if (up_dn) begin
            if (count_out < rollover_val) begin
                step_count = count_out + ONE;
            end else if (sat_mode) begin
                step_count = rollover_val;
            end else begin
                step_count = ONE;
                step_wrap  = 1'b1;
            end
        end else begin
            if (count_out == ONE) begin
                if (!sat_mode) begin
                    step_count = rollover_val;
                    step_wrap  = 1'b1;
                end
            end else if (count_out == '0 || count_out > rollover_val) begin
                step_count = rollover_val;
            end else begin
                step_count = count_out - ONE;
            end
        end
    end

    always_comb begin
        terminal   = up_dn ? rollover_val : ONE;
        next_count = count_out;
        next_wrap  = 1'b0;
        if (load) begin
            next_count = load_val;
        end else if (count_enable) begin
            next_count = step_count;
            next_wrap  = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            wrap_count     <= '0;
        end else if (clear) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            wrap_count     <= '0;
        end else begin
            count_out      <= next_count;
            rollover_flag  <= (next_count == terminal);
            rollover_pulse <= next_wrap;
            if (next_wrap && (wrap_count != '1)) begin
                wrap_count <= wrap_count + NUM_WRAP_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Bench for flex_counter_ud: cycle-by-cycle comparison against an integer
// model of the counting rules, plus hand-computed checkpoints.
module tb_flex_counter_ud;

    localparam int CW = 4;
    localparam int WW = 2;
    localparam int MAX_WRAPS = (1 << WW) - 1;

    logic          clk;
    logic          n_rst;
    logic          clear;
    logic          load;
    logic [CW-1:0] load_val;
    logic          count_enable;
    logic          up_dn;
    logic          sat_mode;
    logic [CW-1:0] rollover_val;
    logic [CW-1:0] count_out;
    logic          rollover_flag;
    logic          rollover_pulse;
    logic [WW-1:0] wrap_count;

    int total;
    int bad;

    int m_count;
    int m_flag;
    int m_pulse;
    int m_wraps;
    int r_val;
    int nxt;
    int wrapped;

    flex_counter_ud #(
        .NUM_CNT_BITS (CW),
        .NUM_WRAP_BITS(WW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .up_dn         (up_dn),
        .sat_mode      (sat_mode),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .wrap_count    (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the counting rules in plain integer arithmetic.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_count = 0; m_flag = 0; m_pulse = 0; m_wraps = 0;
        end else if (clear) begin
            m_count = 0; m_flag = 0; m_pulse = 0; m_wraps = 0;
        end else begin
            r_val   = int'(rollover_val);
            wrapped = 0;
            if (load) nxt = int'(load_val);
            else if (!count_enable) nxt = m_count;
            else if (r_val == 0) nxt = 0;
            else if (up_dn) begin
                if (m_count < r_val) nxt = m_count + 1;
                else if (sat_mode) nxt = r_val;
                else begin nxt = 1; wrapped = 1; end
            end else begin
                if (m_count == 1) begin
                    if (sat_mode) nxt = 1;
                    else begin nxt = r_val; wrapped = 1; end
                end else if (m_count == 0 || m_count > r_val) nxt = r_val;
                else nxt = m_count - 1;
            end
            m_count = nxt;
            m_pulse = wrapped;
            if (wrapped == 1 && m_wraps < MAX_WRAPS) m_wraps = m_wraps + 1;
            m_flag  = (nxt == (up_dn ? r_val : 1)) ? 1 : 0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (n_rst) begin
            check_output("model count", int'(count_out), m_count);
            check_output("model flag", int'(rollover_flag), m_flag);
            check_output("model pulse", int'(rollover_pulse), m_pulse);
            check_output("model wraps", int'(wrap_count), m_wraps);
        end
    end

    task automatic apply_stimulus(input logic clr, input logic ld, input int lv, input logic en,
                                  input logic ud, input logic sat, input int rv);
        clear        = clr;
        load         = ld;
        load_val     = CW'(lv);
        count_enable = en;
        up_dn        = ud;
        sat_mode     = sat;
        rollover_val = CW'(rv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_all(input string name, input int c, input int f, input int p, input int w);
        check_output({name, " count"}, int'(count_out), c);
        check_output({name, " flag"}, int'(rollover_flag), f);
        check_output({name, " pulse"}, int'(rollover_pulse), p);
        check_output({name, " wraps"}, int'(wrap_count), w);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        #7;
        expect_all("reset", 0, 0, 0, 0);
        n_rst = 1'b1;
        tick(1);

        // Up/wrap R=5: 1,2,3,4,5,1,2,3,4,5,1,2
        apply_stimulus(0, 0, 0, 1, 1, 0, 5);
        tick(5);
        expect_all("up5 at5", 5, 1, 0, 0);
        tick(1);
        expect_all("up5 wrap1", 1, 0, 1, 1);
        tick(6);
        expect_all("up5 end", 2, 0, 0, 2);

        // Down/wrap R=5 from 0: 5,4,3,2,1,5
        apply_stimulus(1, 0, 0, 0, 0, 0, 5);
        tick(1);
        expect_all("clear", 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 5);
        tick(1);
        expect_all("dn 0to5", 5, 0, 0, 0);
        tick(4);
        expect_all("dn at1", 1, 1, 0, 0);
        tick(1);
        expect_all("dn wrap", 5, 0, 1, 1);

        // Saturate up R=3, then out-of-range load
        apply_stimulus(1, 0, 0, 0, 1, 1, 3);
        tick(1);
        apply_stimulus(0, 0, 0, 1, 1, 1, 3);
        tick(6);
        expect_all("sat up", 3, 1, 0, 0);
        apply_stimulus(0, 1, 7, 0, 1, 1, 3);
        tick(1);
        expect_all("load7", 7, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 1, 1, 3);
        tick(1);
        expect_all("sat clamp", 3, 1, 0, 0);

        // Priority: build a wrap, then clear+load+enable, then load+enable
        apply_stimulus(0, 0, 0, 1, 1, 0, 2);
        tick(1);
        expect_all("pre prio", 1, 0, 1, 1);
        apply_stimulus(1, 1, 9, 1, 1, 0, 2);
        tick(1);
        expect_all("clr prio", 0, 0, 0, 0);
        apply_stimulus(0, 1, 9, 1, 1, 0, 12);
        tick(1);
        expect_all("load prio", 9, 0, 0, 0);

        // Degenerate R=0
        apply_stimulus(0, 0, 0, 1, 1, 0, 0);
        tick(1);
        expect_all("r0 up", 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        tick(1);
        expect_all("r0 dn", 0, 0, 0, 0);

        // Direction change while idle is reflected in the flag
        apply_stimulus(0, 1, 1, 0, 0, 0, 6);
        tick(1);
        expect_all("idle dn", 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 6);
        tick(1);
        expect_all("idle up", 1, 0, 0, 0);

        // Wrap counter saturation, R=2 up/wrap for 20 cycles
        apply_stimulus(1, 0, 0, 0, 1, 0, 2);
        tick(1);
        apply_stimulus(0, 0, 0, 1, 1, 0, 2);
        tick(5);
        expect_all("wsat 5", 1, 0, 1, 2);
        tick(15);
        expect_all("wsat 20", 2, 1, 0, 3);

        // Asynchronous reset mid-count
        apply_stimulus(1, 0, 0, 0, 1, 0, 9);
        tick(1);
        apply_stimulus(0, 0, 0, 1, 1, 0, 9);
        tick(4);
        expect_all("pre areset", 4, 0, 0, 0);
        #1;
        n_rst = 1'b0;
        #1;
        expect_all("areset", 0, 0, 0, 0);
        #1;
        n_rst = 1'b1;
        tick(1);
        expect_all("post areset", 1, 0, 0, 0);

        apply_stimulus(0, 0, 0, 0, 1, 0, 9);
        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
